// File: rtl/sm_be_poll_sched.sv
// Best-effort endpoint polling scheduler: walks the receive endpoints in turn,
// reads a size word and its payload flits over a request/ack register port,
// forwards accepted words to the packet checker and drains oversize packets.
module sm_be_poll_sched #(
    parameter int NUM_EP   = 2,
    parameter int MAX_LEN  = 8,
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 64,
    localparam int EP_WIDTH = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                rd_req,
    output logic [EP_WIDTH-1:0] rd_ep,
    input  logic                rd_ack,
    input  logic [31:0]         rd_data,
    output logic                chk_enable,
    output logic [31:0]         chk_data,
    output logic [EP_WIDTH-1:0] chk_ep,
    output logic                chk_flush,
    output logic                pkt_done,
    output logic                len_err,
    output logic                timeout_err,
    output logic                busy
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    // Wait limit fires on the cycle the counter would reach TIMEOUT;
    // POLL_GAP of 0 or 1 both give a single GAP cycle.
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST  = (POLL_GAP > 1) ? GAP_W'(POLL_GAP - 1) : '0;
    localparam logic [EP_WIDTH-1:0] EP_LAST   = EP_WIDTH'(NUM_EP - 1);
    localparam logic [15:0]         MAX_SIZE  = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SIZE, FLIT, GAP} state_t;

    state_t              state, state_d;
    logic [EP_WIDTH-1:0] ep, ep_d;
    logic [15:0]         remaining, remaining_d;
    logic                discard, discard_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [GAP_W-1:0]    gap_cnt, gap_d;
    logic                rd_req_d;
    logic                chk_enable_d, chk_flush_d, pkt_done_d, len_err_d, timeout_err_d;
    logic [31:0]         chk_data_d;
    logic [EP_WIDTH-1:0] chk_ep_d;
    logic                advance;
    logic [15:0]         size_word;
    logic                oversize;

    assign size_word = rd_data[15:0];
    assign oversize  = size_word > MAX_SIZE;
    assign rd_ep     = ep;
    assign busy      = (state != IDLE);

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ep          <= '0;
            remaining   <= '0;
            discard     <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            rd_req      <= 1'b0;
            chk_enable  <= 1'b0;
            chk_data    <= '0;
            chk_ep      <= '0;
            chk_flush   <= 1'b0;
            pkt_done    <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            ep          <= ep_d;
            remaining   <= remaining_d;
            discard     <= discard_d;
            wait_cnt    <= wait_d;
            gap_cnt     <= gap_d;
            rd_req      <= rd_req_d;
            chk_enable  <= chk_enable_d;
            chk_data    <= chk_data_d;
            chk_ep      <= chk_ep_d;
            chk_flush   <= chk_flush_d;
            pkt_done    <= pkt_done_d;
            len_err     <= len_err_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state, read handshake, forwarding and endpoint advance.
    always_comb begin
        state_d       = state;
        ep_d          = ep;
        remaining_d   = remaining;
        discard_d     = discard;
        wait_d        = wait_cnt;
        gap_d         = gap_cnt;
        rd_req_d      = rd_req;
        chk_enable_d  = 1'b0;
        chk_data_d    = chk_data;
        chk_ep_d      = chk_ep;
        chk_flush_d   = 1'b0;
        pkt_done_d    = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        advance       = 1'b0;

        case (state)
            IDLE: begin
                rd_req_d = 1'b0;
                if (en) state_d = SIZE;
            end
            SIZE, FLIT: begin
                if (!rd_req) begin
                    // One low cycle after every completed read, then request.
                    rd_req_d = 1'b1;
                    wait_d   = '0;
                end else if (rd_ack) begin
                    rd_req_d = 1'b0;
                    wait_d   = '0;
                    if (state == SIZE) begin
                        if (size_word == '0) begin
                            advance = 1'b1;
                        end else begin
                            remaining_d = size_word;
                            discard_d   = oversize;
                            state_d     = FLIT;
                            if (!oversize) begin
                                chk_enable_d = 1'b1;
                                chk_data_d   = rd_data;
                                chk_ep_d     = ep;
                            end
                        end
                    end else begin
                        remaining_d = remaining - 16'd1;
                        if (!discard) begin
                            chk_enable_d = 1'b1;
                            chk_data_d   = rd_data;
                            chk_ep_d     = ep;
                        end
                        if (remaining == 16'd1) begin
                            pkt_done_d = !discard;
                            len_err_d  = discard;
                            advance    = 1'b1;
                        end
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    rd_req_d      = 1'b0;
                    wait_d        = '0;
                    timeout_err_d = 1'b1;
                    chk_flush_d   = (state == FLIT) && !discard;
                    advance       = 1'b1;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = en ? SIZE : IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            remaining_d = '0;
            discard_d   = 1'b0;
            if (ep == EP_LAST) begin
                ep_d    = '0;
                gap_d   = '0;
                state_d = GAP;
            end else begin
                ep_d    = ep + EP_WIDTH'(1);
                state_d = en ? SIZE : IDLE;
            end
        end
    end

endmodule

// File: doc/sm_be_poll_sched.md
SM_BE_POLL_SCHED -- requirements
Module: sm_be_poll_sched

Interface
REQ-001 The block SHALL have parameter NUM_EP, default 2, giving the number of BE receive endpoints polled.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, giving the maximum accepted packet size in flits, excluding the size word.
REQ-003 The block SHALL have parameter POLL_GAP, default 16, giving the idle cycles between polling rounds.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for rd_ack.
REQ-005 The block SHALL define EP_WIDTH = max(1, clog2(NUM_EP)).
REQ-006 Port clk  in  1  clock; all logic is on the rising edge.
REQ-007 Port rst  in  1  reset; synchronous, active-high.
REQ-008 Port en  in  1  polling enable.
REQ-009 Port rd_req  out  1  read request to the endpoint register interface.
REQ-010 Port rd_ep  out  EP_WIDTH  endpoint index of the current read.
REQ-011 Port rd_ack  in  1  read complete; rd_data is valid in the same cycle.
REQ-012 Port rd_data  in  32  read data word.
REQ-013 Port chk_enable  out  1  word strobe to the BE packet checker.
REQ-014 Port chk_data  out  32  word to the checker.
REQ-015 Port chk_ep  out  EP_WIDTH  endpoint the forwarded word came from.
REQ-016 Port chk_flush  out  1  one-cycle pulse; the checker discards its partial packet.
REQ-017 Port pkt_done  out  1  one-cycle pulse; a packet was fully forwarded.
REQ-018 Port len_err  out  1  one-cycle pulse; an oversize packet was drained.
REQ-019 Port timeout_err  out  1  one-cycle pulse; a read timed out.
REQ-020 Port busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have exactly four states:
- IDLE: waits for en=1, then goes to SIZE.
- SIZE: reads the size word.
- FLIT: reads payload flits.
- GAP: counts POLL_GAP cycles, then goes to SIZE if en=1, else IDLE.
REQ-022 In SIZE and FLIT, rd_req SHALL be held high until rd_ack, then driven low for exactly one cycle before the next request; rd_ack while rd_req=0 is ignored.
REQ-023 rd_ep SHALL equal the current endpoint index and be stable while rd_req=1.
REQ-024 A forwarded word SHALL appear on chk_data with chk_enable=1 and chk_ep for exactly one cycle, the cycle after its rd_ack (registered, latency 1).
REQ-025 On SIZE ack, size = rd_data[15:0], with this handling:
- size=0: nothing forwarded; advance endpoint.
- 1<=size<=MAX_LEN: forward the word; remaining=size; discard=0; go to FLIT.
- size>MAX_LEN: do not forward; remaining=size; discard=1; go to FLIT.
REQ-026 On each FLIT ack, the word SHALL be forwarded if discard=0, and remaining (16-bit) SHALL decrement.
REQ-027 When remaining reaches 0, the block SHALL pulse pkt_done (discard=0) or len_err (discard=1) in the same cycle as the last chk_enable, and advance the endpoint.
REQ-028 Advancing the endpoint SHALL work as follows:
- If ep<NUM_EP-1: ep+1, then SIZE if en=1, else IDLE.
- If ep=NUM_EP-1: ep=0, then GAP.
REQ-029 en SHALL be sampled only at packet boundaries: endpoint advance, IDLE, and end of GAP. Deasserting en mid-packet SHALL NOT stop the packet.
REQ-030 The wait counter SHALL count cycles with rd_req=1 and no rd_ack, and SHALL clear on every ack.
REQ-031 On a timeout (wait counter reaching TIMEOUT), the block SHALL:
- drop rd_req;
- pulse timeout_err;
- pulse chk_flush if in FLIT with discard=0;
- advance the endpoint.
REQ-032 If rd_ack arrives in the same cycle the wait counter reaches TIMEOUT, the ack SHALL win and no timeout SHALL occur.
REQ-033 The GAP counter SHALL count 0..POLL_GAP-1; with POLL_GAP=0, GAP SHALL last 1 cycle.

Reset
REQ-034 While rst=1, the block SHALL force state=IDLE, ep=0, remaining=0, discard=0, all counters 0, and all outputs 0, including mid-transfer.

Verification
REQ-035 NUM_EP=2, en=1, ep0 returns size 0, ep1 returns size 0 -> two reads, no chk_enable, GAP of 16 cycles, then polling restarts at ep0.
REQ-036 ep0 returns size 3 then flits A,B,C -> chk_enable for 4 words (3,A,B,C) with chk_ep=0, each 1 cycle after its ack; pkt_done on the C cycle.
REQ-037 ep1 returns size 12 (MAX_LEN=8) -> 12 flit reads, no chk_enable, len_err pulse after the 12th ack, then GAP.
REQ-038 ep0 returns size 4; rd_ack withheld after the 2nd flit -> timeout_err and chk_flush exactly 64 cycles after rd_req rises; next read targets ep1.
REQ-039 rd_ack asserted on the 64th wait cycle -> no timeout_err; the word is forwarded normally.
REQ-040 en dropped mid-packet, then rst asserted during FLIT -> the packet completes after en drops and the block goes to IDLE; on rst, rd_req=0 and busy=0 in the next cycle.
